// File: rtl/systolic_host_ctrl_if.sv
// Job link between the host controller and the systolic engine:
// request pulse, operand stream out, result stream back.
interface systolic_host_ctrl_if #(
    parameter int DATA_W = 64
);
    logic              req_valid;
    logic              tx_valid;
    logic [DATA_W-1:0] tx_data;
    logic              tx_ready;
    logic              rx_valid;
    logic [DATA_W-1:0] rx_data;
    logic              rx_ready;

    modport master (
        output req_valid,
        output tx_valid,
        output tx_data,
        output rx_ready,
        input  tx_ready,
        input  rx_valid,
        input  rx_data
    );

    modport slave (
        input  req_valid,
        input  tx_valid,
        input  tx_data,
        input  rx_ready,
        output tx_ready,
        output rx_valid,
        output rx_data
    );
endinterface

// File: rtl/systolic_host_ctrl.sv
// Host-side job controller for the 4x4 int8 systolic engine:
// operand buffer, request/stream-out, result capture and timeout.
module systolic_host_ctrl #(
    parameter int DATA_W  = 64,
    parameter int N_IN    = 4,
    parameter int N_OUT   = 8,
    parameter int TIMEOUT = 4096
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [$clog2(N_IN)-1:0]  wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     start,
    input  logic [$clog2(N_OUT)-1:0] rd_addr,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     busy,
    output logic                     done,
    output logic                     error,
    systolic_host_ctrl_if.master     link
);

    localparam int IW = $clog2(N_IN);
    localparam int OW = $clog2(N_OUT);
    localparam int TW = $clog2(TIMEOUT);

    localparam logic [IW-1:0] IN_LAST  = IW'(N_IN - 1);
    localparam logic [OW-1:0] OUT_LAST = OW'(N_OUT - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_SEND,
        S_WAIT_RES,
        S_COLLECT,
        S_FIN,
        S_ERR
    } state_t;

    state_t            state;
    logic [IW-1:0]     in_cnt;
    logic [OW-1:0]     out_cnt;
    logic [TW-1:0]     tmo;

    logic              busy_q;
    logic              done_q;
    logic              error_q;
    logic              req_q;
    logic              txv_q;
    logic [DATA_W-1:0] txd_q;
    logic              rxr_q;

    logic [DATA_W-1:0] opbuf  [N_IN];
    logic [DATA_W-1:0] resbuf [N_OUT];

    logic              tx_fire;
    logic              rx_fire;
    logic              op_wr;
    logic [DATA_W-1:0] op0_next;

    // txv_q/rxr_q are high exactly in SEND and WAIT_RES/COLLECT
    assign tx_fire = txv_q & link.tx_ready;
    assign rx_fire = rxr_q & link.rx_valid;
    assign op_wr   = wr_en & (state != S_SEND);

    // A write to word 0 during REQ must reach the first beat
    assign op0_next = (op_wr && wr_addr == '0) ? wr_data : opbuf[0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_IN; i++) begin
                opbuf[i] <= '0;
            end
        end else if (op_wr) begin
            opbuf[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_OUT; i++) begin
                resbuf[i] <= '0;
            end
        end else if (rx_fire) begin
            resbuf[out_cnt] <= link.rx_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            in_cnt  <= '0;
            out_cnt <= '0;
            tmo     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            req_q   <= 1'b0;
            txv_q   <= 1'b0;
            txd_q   <= '0;
            rxr_q   <= 1'b0;
        end else begin
            req_q <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        state   <= S_REQ;
                        req_q   <= 1'b1;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        error_q <= 1'b0;
                    end
                end
                S_REQ: begin
                    state  <= S_SEND;
                    in_cnt <= '0;
                    txv_q  <= 1'b1;
                    txd_q  <= op0_next;
                end
                S_SEND: begin
                    if (tx_fire) begin
                        if (in_cnt == IN_LAST) begin
                            state   <= S_WAIT_RES;
                            txv_q   <= 1'b0;
                            rxr_q   <= 1'b1;
                            out_cnt <= '0;
                            tmo     <= '0;
                        end else begin
                            in_cnt <= in_cnt + 1'b1;
                            txd_q  <= opbuf[in_cnt + 1'b1];
                        end
                    end
                end
                S_WAIT_RES, S_COLLECT: begin
                    // An accepted beat wins over an expiring timeout
                    if (rx_fire) begin
                        tmo <= '0;
                        if (out_cnt == OUT_LAST) begin
                            state  <= S_FIN;
                            rxr_q  <= 1'b0;
                            done_q <= 1'b1;
                            busy_q <= 1'b0;
                        end else begin
                            state   <= S_COLLECT;
                            out_cnt <= out_cnt + 1'b1;
                        end
                    end else if (tmo == TMO_LAST) begin
                        state   <= S_ERR;
                        rxr_q   <= 1'b0;
                        error_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end
                S_FIN, S_ERR: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign rd_data        = resbuf[rd_addr];
    assign busy           = busy_q;
    assign done           = done_q;
    assign error          = error_q;
    assign link.req_valid = req_q;
    assign link.tx_valid  = txv_q;
    assign link.tx_data   = txd_q;
    assign link.rx_ready  = rxr_q;

endmodule
